// File: rtl/fs_ds_inst_queue.sv
// rtl/fs_ds_inst_queue.sv - fetch-to-decode instruction queue with ADEF tagging and flush
// Circular buffer; wrap-bit pointers distinguish full from empty without a separate counter.
module fs_ds_inst_queue #(
  parameter int                DEPTH  = 4,
  parameter int                PC_W   = 32,
  parameter int                INST_W = 32,
  parameter logic [INST_W-1:0] NOP    = 32'h0340_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic                     out_adef,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic              mem_adef [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];
  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_idx == wr_idx) && (rd_ptr[AW] != wr_ptr[AW]);

  // Handshakes depend only on registered state, so fetch never sees out_ready combinationally.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Payload storage is not reset; empty gating below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_idx]   <= in_pc;
      mem_inst[wr_idx] <= in_inst;
      mem_adef[wr_idx] <= (in_pc[1:0] != 2'b00);
    end
  end

  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    out_adef = 1'b0;
    if (!empty) begin
      out_pc   = mem_pc[rd_idx];
      out_adef = mem_adef[rd_idx];
      out_inst = mem_adef[rd_idx] ? NOP : mem_inst[rd_idx];
    end
  end

endmodule

// File: tb/tb_fs_ds_inst_queue.sv
// tb/tb_fs_ds_inst_queue.sv - directed self-checking bench for fs_ds_inst_queue
module tb_fs_ds_inst_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;
  logic [2:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fs_ds_inst_queue dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_adef  (out_adef),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] head;
    logic [31:0] tail;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    step(); step();
    reset = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_inst",  64'(out_inst),  64'd0);
    check("rst_out_adef",  64'(out_adef),  64'd0);

    // single push becomes visible the following cycle
    push_one(32'h1C00_0000, 32'h0280_0C0C);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_pc",    64'(out_pc),    64'h1C00_0000);
    check("t1_out_inst",  64'(out_inst),  64'h0280_0C0C);
    check("t1_count",     64'(count),     64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t1_drained", 64'(count), 64'd0);

    // five back-to-back pushes into a depth-4 queue
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h1C00_0000 + 32'(4 * i);
      in_inst  = 32'h0000_1000 + 32'(i);
      check($sformatf("t2_in_ready_%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
      step();
    end
    in_valid = 1'b0;
    check("t2_count_full", 64'(count), 64'd4);
    check("t2_in_ready",   64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("t2_drain_pc_%0d", i), 64'(out_pc), 64'h1C00_0000 + 64'(4 * i));
      check($sformatf("t2_drain_inst_%0d", i), 64'(out_inst), 64'h0000_1000 + 64'(i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("t2_empty_valid", 64'(out_valid), 64'd0);
    check("t2_empty_count", 64'(count), 64'd0);

    // steady push+pop at count 2
    head = 32'h1C00_1000;
    tail = head;
    push_one(tail, 32'hA000_0000); tail += 4;
    push_one(tail, 32'hA000_0000); tail += 4;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t3_count_%0d", i), 64'(count), 64'd2);
      check($sformatf("t3_pc_%0d", i), 64'(out_pc), 64'(head));
      in_valid = 1'b1; in_pc = tail; in_inst = 32'hA000_0000;
      out_ready = 1'b1;
      step();
      head += 4;
      tail += 4;
    end
    idle();
    check("t3_count_end", 64'(count), 64'd2);
    check("t3_pc_end", 64'(out_pc), 64'(head));
    do_flush();

    // flush beats a simultaneous push and pop
    push_one(32'h1C00_0100, 32'h1);
    push_one(32'h1C00_0104, 32'h2);
    push_one(32'h1C00_0108, 32'h3);
    check("t4_count3", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h1C00_DEAD; out_ready = 1'b1;
    check("t4_in_ready_flush", 64'(in_ready), 64'd1);
    step();
    idle();
    check("t4_count", 64'(count), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd1);
    push_one(32'h1C00_2000, 32'h5);
    check("t4_fresh_pc", 64'(out_pc), 64'h1C00_2000);
    check("t4_fresh_count", 64'(count), 64'd1);
    do_flush();

    // misaligned PC gets ADEF and NOP; aligned follower is untouched
    push_one(32'h1C00_0002, 32'hFFFF_FFFF);
    push_one(32'h1C00_0008, 32'h1234_5678);
    check("t5_adef", 64'(out_adef), 64'd1);
    check("t5_inst", 64'(out_inst), 64'h0340_0000);
    check("t5_pc",   64'(out_pc),   64'h1C00_0002);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t5_next_adef", 64'(out_adef), 64'd0);
    check("t5_next_inst", 64'(out_inst), 64'h1234_5678);
    do_flush();

    // reset while full
    for (int i = 0; i < 4; i++) push_one(32'h1C00_3000 + 32'(4 * i), 32'h7);
    check("t6_count_full", 64'(count), 64'd4);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_count", 64'(count), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_out_pc", 64'(out_pc), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
